// File: rtl/tmdb_mpu_pkg.sv
// Shared defaults for the peak-detector array and the width rule used by
// the saturating neighbour sum.
package tmdb_mpu_pkg;

   localparam int PD_W      = 19;
   localparam int PD_NCH    = 4;
   localparam int PD_HW     = 4;
   localparam int PD_CW     = 16;
   localparam int PRIME_LEN = 3;

   // Adding two W-bit signed values needs one extra bit before saturation.
   function automatic int sat_sum_width(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/pd_channel.sv
// One detector channel: 3-tap shift register, strict peak/threshold compare,
// hold-off suppression after a low-threshold hit, and a saturating hit counter.
module pd_channel #(
   parameter int W  = 19,
   parameter int HW = 4,
   parameter int CW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift,
   input  logic                flush,
   input  logic                armed,
   input  logic signed [W-1:0] sample_in,
   input  logic signed [W-1:0] lt,
   input  logic signed [W-1:0] ht,
   input  logic [HW-1:0]       holdoff,
   input  logic                clr_cnt,
   output logic                pd,
   output logic                llt,
   output logic                hlt,
   output logic signed [W-1:0] peak,
   output logic [CW-1:0]       hit_cnt
);

   logic signed [W-1:0] t0_q, t1_q, t2_q, t0_d, t1_d, t2_d;
   logic signed [W-1:0] peak_q, peak_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pd_q, pd_d, llt_q, llt_d, hlt_q, hlt_d;
   logic                suppress, raw_pd;

   // Flags are judged on the taps as they will look after this shift.
   always_comb begin
      t0_d = flush ? '0 : t0_q;
      t1_d = flush ? '0 : t1_q;
      t2_d = flush ? '0 : t2_q;
      if (shift) begin
         t2_d = t1_d;
         t1_d = t0_d;
         t0_d = sample_in;
      end
      suppress = (hold_q != '0);
      raw_pd   = (t0_d < t1_d) && (t1_d > t2_d);
      pd_d     = shift && armed && !suppress && raw_pd;
      llt_d    = pd_d && (t1_d > lt);
      hlt_d    = pd_d && (t1_d > ht);
      hold_d   = hold_q;
      if (shift) begin
         if (suppress) begin
            hold_d = hold_q - HW'(1);
         end else if (llt_d) begin
            hold_d = holdoff;
         end
      end
      peak_d = shift ? t1_d : peak_q;
      cnt_d  = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (hlt_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t0_q   <= '0;
         t1_q   <= '0;
         t2_q   <= '0;
         peak_q <= '0;
         hold_q <= '0;
         cnt_q  <= '0;
         pd_q   <= 1'b0;
         llt_q  <= 1'b0;
         hlt_q  <= 1'b0;
      end else begin
         t0_q   <= t0_d;
         t1_q   <= t1_d;
         t2_q   <= t2_d;
         peak_q <= peak_d;
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
         pd_q   <= pd_d;
         llt_q  <= llt_d;
         hlt_q  <= hlt_d;
      end
   end

   assign pd      = pd_q;
   assign llt     = llt_q;
   assign hlt     = hlt_q;
   assign peak    = peak_q;
   assign hit_cnt = cnt_q;

endmodule

// File: rtl/peak_detect_array.sv
// Multi-channel peak detector: optional saturating neighbour sum per channel,
// shared priming/flush control, and NCH independent detector channels.
module peak_detect_array
   import tmdb_mpu_pkg::*;
#(
   parameter int W   = PD_W,
   parameter int NCH = PD_NCH,
   parameter int HW  = PD_HW,
   parameter int CW  = PD_CW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [NCH*W-1:0]  samples,
   input  logic [NCH*W-1:0]  lt,
   input  logic [NCH*W-1:0]  ht,
   input  logic              sum_mode,
   input  logic [HW-1:0]     holdoff,
   input  logic              clr_cnt,
   output logic              out_valid,
   output logic [NCH-1:0]    pd,
   output logic [NCH-1:0]    llt,
   output logic [NCH-1:0]    hlt,
   output logic [NCH*W-1:0]  peak,
   output logic [NCH*CW-1:0] hit_cnt
);

   localparam int         SW         = sat_sum_width(W);
   localparam logic [1:0] PRIME_FULL = 2'(PRIME_LEN);

   logic       mode_q, mode_d, valid_q, valid_d;
   logic [1:0] prime_q, prime_d;
   logic       flush, armed;

   // A mode switch empties the taps, so priming restarts with this sample.
   always_comb begin
      flush   = (sum_mode != mode_q);
      mode_d  = sum_mode;
      valid_d = in_valid;
      prime_d = flush ? '0 : prime_q;
      if (in_valid && (prime_d != PRIME_FULL)) begin
         prime_d = prime_d + 2'd1;
      end
      armed = (prime_d == PRIME_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= 1'b0;
         valid_q <= 1'b0;
         prime_q <= '0;
      end else begin
         mode_q  <= mode_d;
         valid_q <= valid_d;
         prime_q <= prime_d;
      end
   end

   assign out_valid = valid_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam int J = (i + 1) % NCH;
      logic signed [W-1:0]  a, b, ch_in;
      logic signed [SW-1:0] sum;

      assign a   = samples[i*W +: W];
      assign b   = samples[J*W +: W];
      assign sum = SW'(a) + SW'(b);

      // Differing top two bits of the widened sum mean it left the W-bit range.
      always_comb begin
         ch_in = a;
         if (sum_mode) begin
            if (sum[SW-1] != sum[SW-2]) begin
               ch_in = sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
               ch_in = sum[W-1:0];
            end
         end
      end

      pd_channel #(
         .W  (W),
         .HW (HW),
         .CW (CW)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .shift     (in_valid),
         .flush     (flush),
         .armed     (armed),
         .sample_in (ch_in),
         .lt        (lt[i*W +: W]),
         .ht        (ht[i*W +: W]),
         .holdoff   (holdoff),
         .clr_cnt   (clr_cnt),
         .pd        (pd[i]),
         .llt       (llt[i]),
         .hlt       (hlt[i]),
         .peak      (peak[i*W +: W]),
         .hit_cnt   (hit_cnt[i*CW +: CW])
      );
   end

endmodule

// File: tb/tb_peak_detect_array.sv
// Randomized bench for peak_detect_array against a sample-history reference
// model, with directed cases for saturation, plateaus, hold-off and flushing.
module tb_peak_detect_array;

   localparam int     W    = 19;
   localparam int     NCH  = 4;
   localparam int     HW   = 4;
   localparam int     CW   = 5;
   localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W - 1));
   localparam longint CMAX = (longint'(1) <<< CW) - 1;

   logic              clk, rst, in_valid, sum_mode, clr_cnt, out_valid;
   logic [NCH*W-1:0]  samples, lt, ht, peak;
   logic [HW-1:0]     holdoff;
   logic [NCH-1:0]    pd, llt, hlt;
   logic [NCH*CW-1:0] hit_cnt;

   longint         s_in[NCH], lt_in[NCH], ht_in[NCH];
   int             hold_in;
   longint         hist[$];
   int             hold_m[NCH];
   longint         cnt_m[NCH], peak_m[NCH];
   logic [NCH-1:0] pd_m, llt_m, hlt_m;
   logic           ov_m, mode_prev;
   int             checks, failures;

   peak_detect_array #(
      .W   (W),
      .NCH (NCH),
      .HW  (HW),
      .CW  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .samples   (samples),
      .lt        (lt),
      .ht        (ht),
      .sum_mode  (sum_mode),
      .holdoff   (holdoff),
      .clr_cnt   (clr_cnt),
      .out_valid (out_valid),
      .pd        (pd),
      .llt       (llt),
      .hlt       (hlt),
      .peak      (peak),
      .hit_cnt   (hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [63:0] got,
                              input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Value seen by channel c for the sample currently on the inputs.
   function automatic longint chanInput(int c);
      longint v;
      if (!sum_mode) return s_in[c];
      v = s_in[c] + s_in[(c + 1) % NCH];
      if (v > SMAX) v = SMAX;
      else if (v < SMIN) v = SMIN;
      return v;
   endfunction

   // k samples back in the fresh history (0 = newest); absent samples read as 0.
   function automatic longint tapAt(int k, int c);
      int idx;
      idx = hist.size() - NCH * (k + 1) + c;
      return (idx >= 0) ? hist[idx] : 0;
   endfunction

   task automatic modelReset();
      hist.delete();
      for (int c = 0; c < NCH; c++) begin
         hold_m[c] = 0;
         cnt_m[c]  = 0;
         peak_m[c] = 0;
      end
      pd_m = '0; llt_m = '0; hlt_m = '0;
      ov_m = 1'b0;
      mode_prev = 1'b0;
   endtask

   task automatic modelStep();
      longint newest, mid, old;
      pd_m = '0; llt_m = '0; hlt_m = '0;
      if (sum_mode != mode_prev) hist.delete();
      mode_prev = sum_mode;
      ov_m = in_valid;
      if (in_valid) begin
         for (int c = 0; c < NCH; c++) hist.push_back(chanInput(c));
         while (hist.size() > 3 * NCH) void'(hist.pop_front());
         for (int c = 0; c < NCH; c++) begin
            newest = tapAt(0, c);
            mid    = tapAt(1, c);
            old    = tapAt(2, c);
            peak_m[c] = mid;
            if (hold_m[c] > 0) begin
               hold_m[c]--;
            end else if (hist.size() == 3 * NCH && newest < mid && mid > old) begin
               pd_m[c]  = 1'b1;
               llt_m[c] = (mid > lt_in[c]);
               hlt_m[c] = (mid > ht_in[c]);
               if (llt_m[c]) hold_m[c] = hold_in;
               if (hlt_m[c] && cnt_m[c] < CMAX) cnt_m[c]++;
            end
         end
      end
      if (clr_cnt) for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
   endtask

   task automatic compareAll();
      checkOutput("out_valid", out_valid, ov_m);
      checkOutput("pd", pd, pd_m);
      checkOutput("llt", llt, llt_m);
      checkOutput("hlt", hlt, hlt_m);
      for (int c = 0; c < NCH; c++) begin
         checkOutput($sformatf("peak[%0d]", c), $signed(peak[c*W +: W]), peak_m[c]);
         checkOutput($sformatf("hit_cnt[%0d]", c), hit_cnt[c*CW +: CW], cnt_m[c]);
      end
   endtask

   // One clock cycle: drive, predict, then check just after the edge.
   task automatic applyStimulus(input bit iv, input bit mode, input bit clr);
      in_valid = iv;
      sum_mode = mode;
      clr_cnt  = clr;
      for (int c = 0; c < NCH; c++) begin
         samples[c*W +: W] = W'(s_in[c]);
         lt[c*W +: W]      = W'(lt_in[c]);
         ht[c*W +: W]      = W'(ht_in[c]);
      end
      holdoff = HW'(hold_in);
      modelStep();
      @(posedge clk);
      #1;
      compareAll();
   endtask

   task automatic resetDut();
      rst = 1'b1;
      modelReset();
      #1;
      compareAll();
      @(posedge clk);
      #1;
      compareAll();
      rst = 1'b0;
   endtask

   task automatic setLevels(input longint lo, input longint hi, input int ho);
      for (int c = 0; c < NCH; c++) begin
         s_in[c]  = 0;
         lt_in[c] = lo;
         ht_in[c] = hi;
      end
      hold_in = ho;
   endtask

   initial begin
      int tally;
      bit cur_mode;
      logic signed [W-1:0] tmp;
      checks = 0;
      failures = 0;
      rst = 1'b1;
      in_valid = 1'b0; sum_mode = 1'b0; clr_cnt = 1'b0;
      samples = '0; lt = '0; ht = '0; holdoff = '0;
      setLevels(0, 0, 0);
      modelReset();
      @(posedge clk);
      #1;
      resetDut();

      // Basic peak on channel 0.
      setLevels(10, 40, 0);
      s_in[0] = 0;  applyStimulus(1, 0, 0);
      s_in[0] = 50; applyStimulus(1, 0, 0);
      s_in[0] = 30; applyStimulus(1, 0, 0);
      checkOutput("basic out_valid", out_valid, 1);
      checkOutput("basic pd0", pd[0], 1);
      checkOutput("basic llt0", llt[0], 1);
      checkOutput("basic hlt0", hlt[0], 1);
      checkOutput("basic peak0", $signed(peak[W-1:0]), 50);
      checkOutput("basic cnt0", hit_cnt[CW-1:0], 1);
      applyStimulus(0, 0, 0);
      checkOutput("idle out_valid", out_valid, 0);

      // Plateau never detects.
      resetDut();
      tally = 0;
      foreach (s_in[c]) s_in[c] = 0;
      for (int k = 0; k < 4; k++) begin
         s_in[0] = (k == 0 || k == 3) ? 10 : 20;
         applyStimulus(1, 0, 0);
         tally += int'(pd[0]);
      end
      checkOutput("plateau pd count", tally, 0);

      // Saturating neighbour sum, wrapping channel NCH-1 onto channel 0.
      resetDut();
      setLevels(10, 40, 0);
      s_in[NCH-1] = 200000; s_in[0] = 200000;
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkOutput("sat pos peak", $signed(peak[(NCH-1)*W +: W]), 262143);
      s_in[NCH-1] = -200000; s_in[0] = -200000;
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkOutput("sat neg peak", $signed(peak[(NCH-1)*W +: W]), -262144);

      // Hold-off on channel 1, then with hold-off disabled.
      for (int ho = 3; ho >= 0; ho -= 3) begin
         resetDut();
         setLevels(5, 100, ho);
         tally = 0;
         for (int k = 0; k < 10; k++) begin
            s_in[1] = (k % 2 == 1) ? 10 : 0;
            applyStimulus(1, 0, 0);
            tally += int'(pd[1]);
         end
         checkOutput($sformatf("holdoff=%0d pd count", ho), tally, (ho == 3) ? 2 : 4);
      end

      // Hit counter saturation and clear priority.
      resetDut();
      setLevels(100, 20, 0);
      applyStimulus(1, 0, 0);
      for (longint k = 0; k < CMAX; k++) begin
         s_in[0] = 50; applyStimulus(1, 0, 0);
         s_in[0] = 0;  applyStimulus(1, 0, 0);
      end
      checkOutput("cnt full", hit_cnt[CW-1:0], CMAX);
      s_in[0] = 50; applyStimulus(1, 0, 0);
      s_in[0] = 0;  applyStimulus(1, 0, 0);
      checkOutput("cnt sat hlt", hlt[0], 1);
      checkOutput("cnt sat llt", llt[0], 0);
      checkOutput("cnt held", hit_cnt[CW-1:0], CMAX);
      s_in[0] = 50; applyStimulus(1, 0, 0);
      s_in[0] = 0;  applyStimulus(1, 0, 1);
      checkOutput("cnt clr wins", hit_cnt[CW-1:0], 0);

      // Mode toggle mid-stream flushes taps and restarts priming.
      resetDut();
      setLevels(10, 40, 0);
      for (int k = 0; k < 4; k++) begin
         s_in[0] = (k % 2 == 1) ? 50 : 0;
         applyStimulus(1, 0, 0);
      end
      s_in[0] = 0;  applyStimulus(1, 1, 0);
      checkOutput("toggle no peak", pd[0], 0);
      s_in[0] = 50; applyStimulus(1, 1, 0);
      s_in[0] = 0;  applyStimulus(1, 1, 0);
      checkOutput("toggle refire", pd[0], 1);

      // Reset between samples discards the history.
      sum_mode = 1'b0;
      s_in[0] = 0;  applyStimulus(1, 0, 0);
      s_in[0] = 50; applyStimulus(1, 0, 0);
      resetDut();
      s_in[0] = 0;  applyStimulus(1, 0, 0);
      checkOutput("rst no peak", pd[0], 0);
      s_in[0] = 50; applyStimulus(1, 0, 0);
      s_in[0] = 0;  applyStimulus(1, 0, 0);
      checkOutput("rst refire", pd[0], 1);

      // Randomized traffic.
      cur_mode = 1'b0;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            resetDut();
         end else begin
            if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
            for (int c = 0; c < NCH; c++) begin
               case ($urandom_range(0, 9))
                  0: begin
                     tmp = W'($urandom());
                     s_in[c] = longint'(tmp);
                  end
                  1: s_in[c] = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(200000, 262143))
                                                         : -longint'($urandom_range(200000, 262144));
                  default: s_in[c] = longint'($urandom_range(0, 40)) - 20;
               endcase
               lt_in[c] = longint'($urandom_range(0, 30)) - 15;
               ht_in[c] = longint'($urandom_range(0, 30)) - 5;
            end
            hold_in = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, cur_mode, $urandom_range(0, 49) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
